// File: rtl/lut_const_mult_pipe.sv
// Pipelined constant-coefficient multiplier built on an odd-multiple-storage LUT.
// Each 4-bit operand digit is split into an odd LUT multiple and a left shift.
// The shifted partial products are summed exactly. The coefficient can be
// reloaded at run time: the pipeline drains first, then the LUT is rebuilt
// with adds only.
module lut_const_mult_pipe #(
  parameter int unsigned X_WIDTH = 16,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned A_INIT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_WIDTH-1:0]         in_x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [X_WIDTH+A_WIDTH-1:0] out_p,
  input  logic                       coef_load,
  input  logic [A_WIDTH-1:0]         coef_in,
  output logic                       coef_busy
);

  localparam int unsigned ND = X_WIDTH / 4;       // number of 4-bit digits
  localparam int unsigned PW = A_WIDTH + 4;       // partial product width
  localparam int unsigned OW = X_WIDTH + A_WIDTH; // product width

  typedef enum logic [1:0] {
    BUILD = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [PW-1:0]      oms_q [8];
  logic [PW-1:0]      oms_d [8];

  logic               v1_q, v1_d;
  logic [2:0]         idx1_q  [ND];
  logic [2:0]         idx1_d  [ND];
  logic [1:0]         tz1_q   [ND];
  logic [1:0]         tz1_d   [ND];
  logic               zero1_q [ND];
  logic               zero1_d [ND];

  logic               v2_q, v2_d;
  logic [PW-1:0]      pp2_q [ND];
  logic [PW-1:0]      pp2_d [ND];

  logic               v3_q, v3_d;
  logic [OW-1:0]      p3_q, p3_d;

  logic               en_c;
  logic [OW-1:0]      sum_c;

  // Trailing-zero count of a non-zero digit (a zero digit is flagged separately).
  function automatic logic [1:0] tz_of(input logic [3:0] d);
    if (d[0])      return 2'd0;
    else if (d[1]) return 2'd1;
    else if (d[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // LUT index of the odd part: (odd - 1) / 2 == odd >> 1 == d >> (tz + 1).
  function automatic logic [2:0] idx_of(input logic [3:0] d, input logic [1:0] tz);
    return 3'(d >> (int'(tz) + 1));
  endfunction

  assign en_c      = !v3_q || out_ready;
  assign in_ready  = en_c && (state_q == RUN);
  assign coef_busy = (state_q != RUN);
  assign out_valid = v3_q;
  assign out_p     = p3_q;

  // Coefficient FSM: latch the new coefficient, drain, then rebuild the LUT by repeated +2A.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    oms_d   = oms_q;
    unique case (state_q)
      BUILD: begin
        if (k_q == 3'd0) oms_d[0] = PW'(a_q);
        else             oms_d[k_q] = oms_q[k_q - 3'd1] + (PW'(a_q) << 1);
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = RUN;
      end
      RUN: begin
        if (coef_load) begin
          a_d     = coef_in;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!v1_q && !v2_q && !v3_q) begin
          state_d = BUILD;
          k_d     = 3'd0;
        end
      end
      default: begin
        state_d = BUILD;
        k_d     = 3'd0;
      end
    endcase
  end

  // Pipeline next state: digit decode, LUT read and shift, final sum; all under the global stall.
  always_comb begin
    v1_d    = v1_q;
    idx1_d  = idx1_q;
    tz1_d   = tz1_q;
    zero1_d = zero1_q;
    v2_d    = v2_q;
    pp2_d   = pp2_q;
    v3_d    = v3_q;
    p3_d    = p3_q;
    if (en_c) begin
      v1_d = in_valid && in_ready;
      for (int j = 0; j < ND; j++) begin
        zero1_d[j] = (in_x[4*j +: 4] == 4'd0);
        tz1_d[j]   = tz_of(in_x[4*j +: 4]);
        idx1_d[j]  = idx_of(in_x[4*j +: 4], tz_of(in_x[4*j +: 4]));
      end
      v2_d = v1_q;
      for (int j = 0; j < ND; j++) begin
        pp2_d[j] = zero1_q[j] ? '0 : (oms_q[idx1_q[j]] << tz1_q[j]);
      end
      v3_d = v2_q;
      p3_d = sum_c;
    end
  end

  // Weighted sum of partial products; digit j carries weight 16^j.
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < ND; j++) begin
      sum_c = sum_c + (OW'(pp2_q[j]) << (4 * j));
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUILD;
      k_q     <= 3'd0;
      a_q     <= A_WIDTH'(A_INIT);
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p3_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      p3_q    <= p3_d;
    end
  end

  // Datapath registers; contents are qualified by the valid bits or rebuilt before use.
  always_ff @(posedge clk) begin
    oms_q   <= oms_d;
    idx1_q  <= idx1_d;
    tz1_q   <= tz1_d;
    zero1_q <= zero1_d;
    pp2_q   <= pp2_d;
  end

endmodule

// File: tb/tb_lut_const_mult_pipe.sv
// Bench for lut_const_mult_pipe: a transaction-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_lut_const_mult_pipe;
  localparam int unsigned XW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned AI = 2;
  localparam int unsigned OW = XW + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_x = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_p;
  logic          coef_load = 1'b0;
  logic [AW-1:0] coef_in = '0;
  logic          coef_busy;

  always #5 clk = ~clk;

  lut_const_mult_pipe #(.X_WIDTH(XW), .A_WIDTH(AW), .A_INIT(AI)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .coef_load(coef_load), .coef_in(coef_in), .coef_busy(coef_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: transactions in order, coefficient in force, and busy phase.
  typedef struct {
    logic [OW-1:0] val;
    int            stamp;
  } exp_t;
  typedef enum {M_RUN, M_DRAIN, M_BUILD} mphase_e;

  exp_t          exp_q[$];
  logic [OW-1:0] got_q[$];
  mphase_e       ph = M_BUILD;
  int            bcnt = 0;
  logic [AW-1:0] ma = AW'(AI);
  logic [AW-1:0] mpend = AW'(AI);
  int            cyc = 0;
  bit            live = 0;
  int            last_stall = -1;
  bit            prev_stall = 0;
  logic [OW-1:0] prev_p = '0;
  logic [OW-1:0] last_push = '0;

  // Model update on each clock edge from the inputs presented in the ending cycle.
  always @(posedge clk) begin
    bit acc;
    bit pop;
    bit was_empty;
    if (rst) begin
      live = 1;
      ph = M_BUILD;
      bcnt = 0;
      ma = AW'(AI);
      mpend = AW'(AI);
      exp_q.delete();
      last_stall = -1;
      prev_stall = 0;
    end else if (live) begin
      was_empty = (exp_q.size() == 0);
      acc = in_valid && (ph == M_RUN) && (!out_valid || out_ready);
      pop = out_valid && out_ready;
      if (pop) begin
        got_q.push_back(out_p);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (acc) begin
        last_push = OW'(in_x) * OW'(ma);
        exp_q.push_back('{last_push, cyc});
      end
      case (ph)
        M_RUN:   if (coef_load) begin mpend = coef_in; ph = M_DRAIN; end
        M_DRAIN: if (was_empty) begin ph = M_BUILD; bcnt = 0; end
        default: begin
          if (bcnt == 7) begin ph = M_RUN; ma = mpend; end
          else bcnt++;
        end
      endcase
    end
    cyc++;
  end

  // Compare process: checks every DUT output mid-cycle against the model.
  always @(negedge clk) begin
    if (live) begin
      check("coef_busy", coef_busy, ph != M_RUN);
      check("in_ready", in_ready, (ph == M_RUN) && (!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_p", out_p, prev_p);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("out_valid_unexpected", out_valid, 0);
        else begin
          check("out_p", out_p, exp_q[0].val);
          check("latency_min", (cyc - exp_q[0].stamp) >= 3, 1);
        end
      end else if (exp_q.size() > 0 && last_stall < exp_q[0].stamp) begin
        check("latency_exact", (cyc - exp_q[0].stamp) < 3, 1);
      end
      prev_stall = out_valid && !out_ready && !rst;
      prev_p = out_p;
      if (out_valid && !out_ready) last_stall = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (coef_busy === 1'b1 && n < 200) begin n++; step(); end
    if (n >= 200) check("wait_run_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin n++; step(); end
    if (n >= 200) check("drain_timeout", 1, 0);
    step();
  endtask

  task automatic send(input logic [XW-1:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_x = x;
    #1;
    while (!in_ready && n < 200) begin step(); n++; #1; end
    if (n >= 200) check("send_timeout", 1, 0);
    step();
    in_valid = 1'b0;
    in_x = XW'($urandom);
  endtask

  task automatic get_out(output logic [OW-1:0] p, output int lat);
    lat = 1;
    #1;
    while (!out_valid && lat < 50) begin step(); #1; lat++; end
    if (lat >= 50) check("get_out_timeout", 1, 0);
    p = out_p;
  endtask

  task automatic load(input logic [AW-1:0] a);
    coef_load = 1'b1;
    coef_in = a;
    step();
    coef_load = 1'b0;
  endtask

  initial begin
    logic [OW-1:0] p;
    int lat;
    int n;

    // Reset state and post-reset build time
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_coef_busy", coef_busy, 1);
    rst = 1'b0;
    wait_run(n);
    check("build_cycles_after_reset", n, 8);
    #1;
    check("in_ready_after_build", in_ready, 1);

    // A = 2: all-ones operand and zero operand
    out_ready = 1'b1;
    send(16'hFFFF);
    check("model_pin_ffff", last_push, 24'h1FFFE);
    get_out(p, lat);
    check("lat_ffff", lat, 3);
    check("p_ffff", p, 24'h1FFFE);
    wait_drain();
    send(16'h0000);
    get_out(p, lat);
    check("p_zero", p, 0);
    wait_drain();

    // Reload A = 7; mixed zero / even / odd digits
    load(8'h07);
    wait_run(n);
    send(16'h80A0);
    check("model_pin_80a0", last_push, 24'h38460);
    get_out(p, lat);
    check("p_80a0", p, 24'h38460);
    wait_drain();

    // Back-to-back stream with a 5-cycle output stall
    load(8'h02);
    wait_run(n);
    got_q.delete();
    begin
      int idx = 0;
      int stall = 0;
      bit seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (out_valid && !seen) begin seen = 1; stall = 5; end
        out_ready = (stall == 0);
        in_valid = (idx < 4);
        in_x = XW'(idx + 1);
        #1;
        if (stall > 0) check("in_ready_stalled", in_ready, 0);
        if (in_valid && in_ready) idx++;
        if (stall > 0) stall--;
        step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    check("stream_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check($sformatf("stream_%0d", i), got_q[i], 2 * (i + 1));
    end

    // Two in-flight operands, then a reload with a second ignored reload during busy
    got_q.delete();
    in_valid = 1'b1;
    in_x = 16'h1234;
    step();
    step();
    in_valid = 1'b0;
    load(8'hFF);
    n = 0;
    while (coef_busy === 1'b1 && n < 200) begin
      coef_load = (n == 4);
      if (n == 4) coef_in = 8'h03;
      n++;
      step();
    end
    coef_load = 1'b0;
    check("busy_span_drain_build", n, 11);
    check("drain_count", got_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < got_q.size()) check($sformatf("drain_out_%0d", i), got_q[i], 24'h2468);
    end
    send(16'h1234);
    check("model_pin_1234_ff", last_push, 24'h1221CC);
    get_out(p, lat);
    check("p_1234_ff", p, 24'h1221CC);
    wait_drain();

    // Reset in the middle of a rebuild
    load(8'h05);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_run(n);
    check("build_after_mid_build_reset", n, 8);
    send(16'd5);
    get_out(p, lat);
    check("p_5_after_build_reset", p, 24'd10);
    wait_drain();

    // Reset with three operands in flight
    in_valid = 1'b1;
    in_x = 16'd7; step();
    in_x = 16'd8; step();
    in_x = 16'd9; step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("no_stale_valid", out_valid, 0);
    wait_run(n);
    check("build_after_stream_reset", n, 8);
    send(16'd5);
    get_out(p, lat);
    check("p_5_after_stream_reset", p, 24'd10);
    wait_drain();

    // Randomized traffic with occasional reloads and resets
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = XW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      coef_load = ($urandom_range(0, 39) == 0);
      coef_in   = AW'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    in_valid = 1'b0;
    coef_load = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_const_mult_pipe.md
Name: lut_const_mult_pipe

Overview:
- Pipelined, parametrised constant-coefficient multiplier using an odd-multiple-storage (OMS) LUT.
- Splits an X_WIDTH-bit unsigned operand into 4-bit digits and maps each digit to an odd LUT multiple plus a barrel shift. The weighted partial products are summed into the exact product.
- Successor to the fixed 8-bit combinational LUT multiplier. Adds operand-width parametrisation, a 3-stage valid/ready pipeline, and a coefficient that can be reloaded at run time, with the LUT rebuilt in hardware.
- Sits in datapaths as a drop-in streaming constant multiplier.

Parameters:
- X_WIDTH, 16, operand width; multiple of 4, at least 8.
- A_WIDTH, 8, coefficient width.
- A_INIT, 2, coefficient loaded at reset; must fit in A_WIDTH bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block accepts an operand this cycle.
- in_x  input  X_WIDTH  unsigned operand.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts the product.
- out_p  output  X_WIDTH+A_WIDTH  unsigned product in_x*A.
- coef_load  input  1  single-cycle request to load coef_in.
- coef_in  input  A_WIDTH  new coefficient.
- coef_busy  output  1  coefficient change in progress; no operands accepted.

Behaviour:
- LUT: 8 entries of width A_WIDTH+4. Entry oms[i] = (2i+1)*A for i = 0..7.
- Per digit d (4 bits):
  - d = 0 gives partial product 0.
  - Otherwise tz = trailing zeros of d (0..3), odd = d>>tz, partial product = oms[(odd-1)/2] << tz.
  - Partial product width is A_WIDTH+4; 15*A never overflows it.
- Digit j carries weight 16^j. The sum is exact in X_WIDTH+A_WIDTH bits, with no truncation or saturation.
- Pipeline, 3 stages with valid bits v1, v2, v3:
  - S1 registers in_x plus, per digit, the LUT index, tz and a zero flag.
  - S2 performs the LUT read and barrel shift, and registers all partial products.
  - S3 sums the weighted partial products into out_p; out_valid = v3.
- Latency is 3 cycles from an accepted transfer to out_valid, at throughput 1 per cycle.
- Global stall: en = !v3 | out_ready. All stages advance only when en is high.
  - Bubbles are not collapsed.
  - out_p and out_valid hold stable while out_valid & !out_ready.
- in_ready = en & (state == RUN). A transfer occurs when in_valid & in_ready.
- FSM states:
  - BUILD: rebuilds the LUT, 8 cycles, counter k = 0..7. Cycle 0 writes oms[0] = A. Cycle k writes oms[k] = oms[k-1] + 2A, using the adder only (no multiplier). After k = 7 → RUN.
  - RUN: normal operation. coef_load → latch coef_in into the A register (shadow) → DRAIN.
  - DRAIN: in_ready = 0. Stages continue to flush under the stall rule. When v1 = v2 = v3 = 0 → BUILD with the latched A.
- Operands already in flight when coef_load is accepted complete with the old LUT contents. The LUT is not written until DRAIN ends.
- coef_busy = 1 in DRAIN and BUILD, 0 in RUN.
- coef_load in DRAIN or BUILD is ignored: the first load wins and coef_in is not re-sampled.
- coef_load in the same cycle as an accepted operand: the operand is accepted with the old coefficient, and the FSM then enters DRAIN.
- Reset (rst = 1 on a clock edge), including mid-DRAIN, mid-BUILD or mid-stream:
  - v1, v2, v3 = 0; out_valid = 0; out_p = 0; in_ready = 0; coef_busy = 1.
  - A register = A_INIT; state = BUILD, k = 0.
  - In-flight operands are discarded.
- After rst deasserts, 8 BUILD cycles follow, then in_ready rises.
- in_x is ignored when in_valid = 0 or in_ready = 0.

Test Plan:
- Reset, A_INIT = 2, X_WIDTH = 16 → coef_busy = 1 and in_ready = 0 for 8 cycles after rst falls; both flip on the 9th cycle; out_valid = 0 throughout.
- A = 2, in_x = 0xFFFF, out_ready = 1 → out_valid exactly 3 cycles after the transfer, out_p = 0x1FFFE. in_x = 0 → out_p = 0.
- coef_load with coef_in = 0x07, then in_x = 0x80A0 (zero, even and odd digits) → out_p = 0x38460.
- A = 2, stream in_x = 1, 2, 3, 4 back-to-back, with out_ready low for 5 cycles after the first out_valid:
  - outputs are 2, 4, 6, 8 in order, none lost or duplicated;
  - out_p is stable while stalled;
  - in_ready is low while stalled and the pipeline is full.
- A = 2, issue in_x = 0x1234 twice, then coef_load with coef_in = 0xFF in the next cycle:
  - both outputs are 0x2468;
  - coef_busy stays high through drain plus 8 cycles;
  - a second coef_load during busy is ignored;
  - then in_x = 0x1234 → out_p = 0x1221CC.
- Assert rst mid-BUILD, and separately with 3 operands in flight → no stale out_valid; the LUT is rebuilt with A_INIT; in_x = 5 then gives out_p = 10.
